// File: rtl/echo_timer_if.sv
// Handshake bundle between the echo pulse-width timer and its controller.
// The master arms the timer and supplies the raw echo; the slave reports results.
interface echo_timer_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             echo;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [WIDTH-1:0] width;
  logic [WIDTH-1:0] elapsed;

  modport master (
    output start, echo,
    input  busy, done, timeout, width, elapsed
  );

  modport slave (
    input  start, echo,
    output busy, done, timeout, width, elapsed
  );
endinterface

// File: rtl/echo_timer.sv
// Armed pulse-width timer: waits for a fresh echo rising edge, counts prescaled
// ticks while echo is high, and reports the width or a timeout.
module echo_timer #(
  parameter int WIDTH         = 16,
  parameter int PRESCALE      = 100,
  parameter int TIMEOUT_TICKS = 38000
) (
  input  logic       clk,
  input  logic       reset,
  echo_timer_if.slave bus
);

  localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  CNT_LIMIT = WIDTH'(TIMEOUT_TICKS);
  localparam logic [WIDTH-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + WIDTH'(1);
  endfunction

  state_t           state_q, state_d;
  logic             echo_meta_q, echo_meta_d;
  logic             echo_s_q, echo_s_d;
  logic             echo_d_q, echo_d_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic rise;
  logic fall;
  logic pre_wrap;
  logic at_limit;

  assign rise     = echo_s_q & ~echo_d_q;
  assign fall     = ~echo_s_q & echo_d_q;
  assign pre_wrap = (pre_q == PRE_LAST);
  assign at_limit = (cnt_q == CNT_LIMIT);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_d_q    <= 1'b0;
      pre_q       <= '0;
      cnt_q       <= '0;
      width_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      echo_meta_q <= echo_meta_d;
      echo_s_q    <= echo_s_d;
      echo_d_q    <= echo_d_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic; an edge in the limit cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_ARM;
      end
      S_ARM: begin
        if (rise)          state_d = S_MEASURE;
        else if (at_limit) state_d = S_IDLE;
      end
      S_MEASURE: begin
        if (fall)          state_d = S_IDLE;
        else if (at_limit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchroniser, prescaler, tick counter and result capture
  always_comb begin
    echo_meta_d = bus.echo;
    echo_s_d    = echo_meta_q;
    echo_d_d    = echo_s_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    if (state_q != S_IDLE) begin
      pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap) cnt_d = sat_inc(cnt_q);
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          pre_d = '0;
        end
      end
      S_ARM: begin
        // The rise cycle itself is the first high cycle, hence pre restarts at 1
        if (rise) begin
          cnt_d = '0;
          pre_d = PRE_W'(1);
        end else if (at_limit) begin
          width_d   = '1;
          timeout_d = 1'b1;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          width_d = cnt_q;
          done_d  = 1'b1;
        end else if (at_limit) begin
          width_d   = '1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.done    = done_q;
    bus.timeout = timeout_q;
    bus.width   = width_q;
    bus.elapsed = cnt_q;
  end

endmodule

// File: tb/tb_echo_timer.sv
// Directed bench for echo_timer with WIDTH=8, PRESCALE=4, TIMEOUT_TICKS=50.
module tb_echo_timer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  echo_timer_if #(.WIDTH(W)) bus ();

  echo_timer #(
    .WIDTH(W),
    .PRESCALE(4),
    .TIMEOUT_TICKS(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pre_hi;
    int    gap;
    int    hi;
    int    exp_done;
    int    exp_to;
    int    exp_width;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int overlap_cnt = 0;
  int long_pulse_cnt = 0;
  int busy_with_done = 0;
  logic prev_done = 1'b0;
  logic prev_to = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance one cycle; outputs are observed on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.done) done_cnt++;
    if (bus.timeout) to_cnt++;
    if (bus.done && bus.timeout) overlap_cnt++;
    if ((bus.done && prev_done) || (bus.timeout && prev_to)) long_pulse_cnt++;
    if ((bus.done || bus.timeout) && bus.busy) busy_with_done++;
    prev_done = bus.done;
    prev_to = bus.timeout;
  endtask

  task automatic run_case(input vec_t v);
    done_cnt = 0;
    to_cnt = 0;
    bus.echo = (v.pre_hi > 0);
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (v.pre_hi) tick();
    bus.echo = 1'b0;
    repeat (v.gap) tick();
    if (v.hi > 0) begin
      bus.echo = 1'b1;
      repeat (v.hi) tick();
      bus.echo = 1'b0;
    end
    for (int i = 0; i < 400 && (done_cnt + to_cnt) == 0; i++) tick();
    repeat (5) tick();
    chk({v.name, " done"}, done_cnt, v.exp_done);
    chk({v.name, " timeout"}, to_cnt, v.exp_to);
    chk({v.name, " width"}, int'(bus.width), v.exp_width);
    chk({v.name, " busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{"w40",     0,  0,  40, 1, 0, 10};
    vecs[1] = '{"w43",     0,  0,  43, 1, 0, 10};
    vecs[2] = '{"w3",      0,  0,   3, 1, 0, 0};
    vecs[3] = '{"nolow",   0,  0,   0, 0, 1, 255};
    vecs[4] = '{"prehigh", 20, 10, 80, 1, 0, 20};
    vecs[5] = '{"w7",      0,  0,   7, 1, 0, 1};
    vecs[6] = '{"hold300", 0,  0, 300, 0, 1, 255};

    bus.start = 1'b0;
    bus.echo = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst timeout", int'(bus.timeout), 0);
    chk("rst width", int'(bus.width), 0);
    chk("rst elapsed", int'(bus.elapsed), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // Timeout latency from arm with echo held low
    done_cnt = 0;
    to_cnt = 0;
    bus.start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 400 && lat == 0; i++) begin
      tick();
      bus.start = 1'b0;
      if (bus.timeout) lat = i;
    end
    chk("timeout latency", lat, 202);
    chk("timeout no done", done_cnt, 0);
    repeat (3) tick();

    // Echo fall to done latency, then re-arm in the done cycle
    done_cnt = 0;
    to_cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.echo = 1'b1;
    repeat (12) tick();
    bus.echo = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (bus.done) lat = i;
    end
    chk("fall to done latency", lat, 3);
    chk("w12 width", int'(bus.width), 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rearm on done busy", int'(bus.busy), 1);

    // Start pulses while busy must not restart or add a result
    done_cnt = 0;
    tick();
    bus.echo = 1'b1;
    repeat (8) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    bus.echo = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    chk("busy start done count", done_cnt, 1);
    chk("busy start width", int'(bus.width), 4);

    // Reset in the middle of a measurement
    bus.start = 1'b0;
    repeat (200) tick();
    done_cnt = 0;
    to_cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.echo = 1'b1;
    repeat (20) tick();
    chk("pre-reset busy", int'(bus.busy), 1);
    reset = 1'b1;
    tick();
    chk("mid reset busy", int'(bus.busy), 0);
    chk("mid reset width", int'(bus.width), 0);
    chk("mid reset elapsed", int'(bus.elapsed), 0);
    reset = 1'b0;
    bus.echo = 1'b0;
    repeat (10) tick();
    chk("mid reset no done", done_cnt, 0);
    chk("mid reset no timeout", to_cnt, 0);

    chk("done/timeout overlap", overlap_cnt, 0);
    chk("pulse longer than 1", long_pulse_cnt, 0);
    chk("busy during result", busy_with_done, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
